sign_mag_add: RTL and testbench

//  Registered sign-magnitude adder. Operands are N bits wide: the MSB is the sign (1 = negative)
//  and the low N-1 bits are the unsigned magnitude.
//  It adds the operands and returns the result in the same sign-magnitude format, one cycle later.
//  It is a leaf arithmetic element in the datapath; it has no internal pipelining beyond the output register.

---
 rtl/sign_mag_add.sv | 40 ++++
 tb/tb_sign_mag_add.sv | 103 ++++++++++
 2 files changed

// File: rtl/sign_mag_add.sv
// sign_mag_add: registered sign-magnitude adder with overflow flag and zero-sign normalisation
module sign_mag_add #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         out_valid,
    output logic         ovf
);
    logic [N-2:0] ma, mb, diff, mag;
    logic [N-1:0] add;
    logic         same, a_ge, sgn;
    always_comb begin
        ma   = a[N-2:0];
        mb   = b[N-2:0];
        add  = {1'b0, ma} + {1'b0, mb};
        a_ge = ma >= mb;
        diff = a_ge ? ma - mb : mb - ma;
        same = a[N-1] == b[N-1];
        mag  = same ? add[N-2:0] : diff;
        sgn  = (same ? a[N-1] : (a_ge ? a[N-1] : b[N-1])) & |mag;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum <= {sgn, mag};
                ovf <= same & add[N-1];
            end
        end
    end
endmodule

// File: tb/tb_sign_mag_add.sv
// tb_sign_mag_add: directed and random checks of sign_mag_add against an integer reference model
module tb_sign_mag_add;
    localparam int N = 5;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] sum;
    logic         out_valid, ovf;
    int           tests = 0;
    int           fails = 0;
    logic [N-1:0] exp_sum = '0;
    logic         exp_ovf = 1'b0;

    sign_mag_add #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .sum(sum), .out_valid(out_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
        int va, vb, s, m;
        logic o;
        va = x[N-1] ? -int'(x[N-2:0]) : int'(x[N-2:0]);
        vb = y[N-1] ? -int'(y[N-2:0]) : int'(y[N-2:0]);
        s  = va + vb;
        o  = (x[N-1] == y[N-1]) && (int'(x[N-2:0]) + int'(y[N-2:0]) > 2**(N-1) - 1);
        m  = (s < 0 ? -s : s) % (2**(N-1));
        return {o, (s < 0 && m != 0), m[N-2:0]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [N-1:0] x, input logic [N-1:0] y);
        in_valid = v;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        if (v) {exp_ovf, exp_sum} = model(x, y);
        chk("out_valid", 8'(out_valid), 8'(v));
        chk("sum", 8'(sum), 8'(exp_sum));
        chk("ovf", 8'(ovf), 8'(exp_ovf));
    endtask

    task automatic dir(input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [N-1:0] es, input logic eo);
        step(1'b1, x, y);
        chk("dir_sum", 8'(sum), 8'(es));
        chk("dir_ovf", 8'(ovf), 8'(eo));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", 8'(sum), 8'd0);
        chk("rst_valid", 8'(out_valid), 8'd0);
        chk("rst_ovf", 8'(ovf), 8'd0);
        rst_n = 1'b1;
        dir(5'b01000, 5'b11000, 5'b00000, 1'b0);
        dir(5'b10101, 5'b01100, 5'b00111, 1'b0);
        dir(5'b01001, 5'b11111, 5'b10110, 1'b0);
        dir(5'b10110, 5'b00010, 5'b10100, 1'b0);
        dir(5'b11011, 5'b00011, 5'b11000, 1'b0);
        dir(5'b10111, 5'b01001, 5'b00010, 1'b0);
        dir(5'b10000, 5'b10000, 5'b00000, 1'b0);
        dir(5'b01111, 5'b00001, 5'b00000, 1'b1);
        dir(5'b11010, 5'b11001, 5'b10011, 1'b1);
        dir(5'b00111, 5'b00111, 5'b01110, 1'b0);
        dir(5'b01110, 5'b10000, 5'b01110, 1'b0);
        // mid-stream async reset: outputs must clear before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("async_sum", 8'(sum), 8'd0);
        chk("async_valid", 8'(out_valid), 8'd0);
        chk("async_ovf", 8'(ovf), 8'd0);
        exp_sum = '0;
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_sum", 8'(sum), 8'd0);
        rst_n = 1'b1;
        step(1'b1, 5'b01001, 5'b11111);
        step(1'b0, 5'b00101, 5'b00101);
        chk("hs_hold_sum", 8'(sum), 8'b10110);
        step(1'b1, 5'b00011, 5'b00100);
        chk("hs_second_sum", 8'(sum), 8'b00111);
        step(1'b0, 5'b11111, 5'b11111);
        chk("hs_second_hold", 8'(sum), 8'b00111);
        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(0, 1)), N'($urandom), N'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
